// File: rtl/rv_rr_mux.sv
// rv_rr_mux: round-robin multiplexer of CHANNELS ready/valid input streams
// onto one registered ready/valid output stream.
//
// Parameters
//   WIDTH     data bits per channel and on the output
//   CHANNELS  number of input channels (2..16)
//   PKT_MODE  0: arbitrate every beat; 1: hold the grant until in_last
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   per-channel handshake
//   in_data               channel i in bits [i*WIDTH +: WIDTH]
//   in_last               per-channel end-of-packet flag (PKT_MODE=1 only)
//   out_valid / out_ready output handshake
//   out_data, out_id      registered beat and its source channel
//   out_last              registered in_last of the beat (0 when PKT_MODE=0)
module rv_rr_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PKT_MODE = 0,
  localparam int ID_W    = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_last
);

  logic [ID_W-1:0]  ptr_p1;
  logic             lock_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [ID_W-1:0]  id_p1;
  logic             last_p1;

  logic [ID_W-1:0]  grant_p0;
  logic [ID_W-1:0]  cand_p0;
  logic             hit_p0;
  logic [WIDTH-1:0] sel_data_p0;
  logic             sel_last_p0;
  logic             sel_valid_p0;
  logic             load_en_p0;
  logic             arb_active_p0;
  logic             xfer_p0;

  // ---- stage p0: arbitration and input handshake (combinational) ----
  assign load_en_p0    = !vld_p1 || out_ready;
  assign arb_active_p0 = |in_valid;

  // While a packet is locked the grant stays on its channel, even when
  // that channel drops in_valid, so no other channel can interleave.
  always_comb begin
    grant_p0 = ptr_p1;
    cand_p0  = ptr_p1;
    hit_p0   = 1'b0;
    if (!((PKT_MODE != 0) && lock_p1)) begin
      for (int k = 1; k <= CHANNELS; k++) begin
        cand_p0 = ID_W'((int'(ptr_p1) + k) % CHANNELS);
        if (!hit_p0 && in_valid[cand_p0]) begin
          grant_p0 = cand_p0;
          hit_p0   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data_p0  = '0;
    sel_last_p0  = 1'b0;
    sel_valid_p0 = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_p0 == ID_W'(i)) begin
        sel_data_p0  = in_data[i*WIDTH +: WIDTH];
        sel_last_p0  = in_last[i];
        sel_valid_p0 = in_valid[i];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = !reset && load_en_p0 && arb_active_p0 && (grant_p0 == ID_W'(i));
    end
  end

  assign xfer_p0 = !reset && load_en_p0 && arb_active_p0 && sel_valid_p0;

  // ---- stage p1: output register, pointer and packet lock ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= '0;
      last_p1 <= 1'b0;
      lock_p1 <= 1'b0;
      ptr_p1  <= ID_W'(CHANNELS - 1);
    end else if (xfer_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data_p0;
      id_p1   <= grant_p0;
      last_p1 <= (PKT_MODE != 0) && sel_last_p0;
      lock_p1 <= (PKT_MODE != 0) && !sel_last_p0;
      ptr_p1  <= grant_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_id    = id_p1;
  assign out_last  = last_p1;

endmodule

// File: tb/tb_rv_rr_mux.sv
// Testbench for rv_rr_mux: one per-beat instance (dut0) and one packet-mode
// instance (dut1) share a stimulus driver; sel routes it to one of them.
// Expected beats are queued when stimulus is issued and popped by a monitor
// per instance whenever that instance completes an output handshake.
module tb_rv_rr_mux;
  localparam int W  = 8;
  localparam int CH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            sel;
  logic            gen_en;
  logic            rnd_mode;
  logic [CH-1:0]   drv_valid, drv_last, busy, hs, cur_rnd;
  logic [CH*W-1:0] drv_data;
  logic            drv_oready;
  logic [CH-1:0]   sel_ready;

  logic [CH-1:0] iv0, ir0, iv1, ir1;
  logic          ov0, or0, ol0, ov1, or1, ol1;
  logic [W-1:0]  od0, od1;
  logic [1:0]    oid0, oid1;

  assign iv0 = sel ? '0 : drv_valid;
  assign or0 = sel ? 1'b1 : drv_oready;
  assign iv1 = sel ? drv_valid : '0;
  assign or1 = sel ? drv_oready : 1'b1;
  assign sel_ready = sel ? ir1 : ir0;

  rv_rr_mux #(.WIDTH(W), .CHANNELS(CH), .PKT_MODE(0)) dut0 (
    .clock(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0),
    .in_data(drv_data), .in_last(drv_last), .out_valid(ov0), .out_ready(or0),
    .out_data(od0), .out_id(oid0), .out_last(ol0));

  rv_rr_mux #(.WIDTH(W), .CHANNELS(CH), .PKT_MODE(1)) dut1 (
    .clock(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
    .in_data(drv_data), .in_last(drv_last), .out_valid(ov1), .out_ready(or1),
    .out_data(od1), .out_id(oid1), .out_last(ol1));

  typedef struct packed {
    logic       idle;
    logic       last;
    logic [7:0] data;
  } src_t;

  src_t        src [CH][$];
  logic [10:0] exp0 [$];
  logic [10:0] exp1 [$];
  logic [7:0]  chq [CH][$];
  logic [5:0]  seq [CH];
  logic [7:0]  cur_data [CH];
  logic        cur_last [CH];
  int          waitc [CH];
  int          max_wait = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void beat(int ch, logic [7:0] d, logic l);
    src_t s;
    s.idle = 1'b0; s.last = l; s.data = d;
    src[ch].push_back(s);
  endfunction

  function automatic void gap(int ch);
    src_t s;
    s.idle = 1'b1; s.last = 1'b0; s.data = 8'h00;
    src[ch].push_back(s);
  endfunction

  function automatic void ex0(int id, logic [7:0] d, logic l);
    exp0.push_back({l, 2'(id), d});
  endfunction

  function automatic void ex1(int id, logic [7:0] d, logic l);
    exp1.push_back({l, 2'(id), d});
  endfunction

  // Source driver: each channel presents its queue head (or a random beat)
  // and holds it until the handshake; idle entries keep valid low one cycle.
  initial begin
    drv_valid = '0; drv_data = '0; drv_last = '0;
    busy = '0; cur_rnd = '0; hs = '0;
    for (int i = 0; i < CH; i++) begin
      cur_data[i] = 8'h00; cur_last[i] = 1'b0; seq[i] = 6'd0; waitc[i] = 0;
    end
    forever begin
      @(negedge clk);
      hs = drv_valid & sel_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < CH; i++) begin
        if (hs[i]) begin
          if (!cur_rnd[i] && src[i].size() > 0) void'(src[i].pop_front());
          busy[i] = 1'b0;
        end
        if (!busy[i]) begin
          if (gen_en) begin
            if ($urandom_range(0, 1) == 1) begin
              cur_data[i] = {2'(i), seq[i]};
              cur_last[i] = 1'b0;
              chq[i].push_back(cur_data[i]);
              seq[i]++;
              cur_rnd[i] = 1'b1;
              busy[i] = 1'b1;
            end
          end else if (src[i].size() > 0) begin
            if (src[i][0].idle) begin
              void'(src[i].pop_front());
            end else begin
              cur_data[i] = src[i][0].data;
              cur_last[i] = src[i][0].last;
              cur_rnd[i] = 1'b0;
              busy[i] = 1'b1;
            end
          end
        end
        drv_valid[i] = busy[i];
        drv_data[i*W +: W] = cur_data[i];
        drv_last[i] = cur_last[i];
      end
    end
  end

  // Output monitors
  logic [10:0] e0, e1;
  logic [7:0]  er;
  always @(negedge clk) begin
    if (!reset && ov0 && or0) begin
      if (rnd_mode) begin
        chk("rnd beat has a source", 32'(chq[oid0].size() > 0), 32'd1);
        if (chq[oid0].size() > 0) begin
          er = chq[oid0].pop_front();
          chk("rnd channel order", 32'(od0), 32'(er));
        end
      end else begin
        chk("dut0 beat expected", 32'(exp0.size() > 0), 32'd1);
        if (exp0.size() > 0) begin
          e0 = exp0.pop_front();
          chk("dut0 beat {last,id,data}", 32'({ol0, oid0, od0}), 32'(e0));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ov1 && or1) begin
      chk("dut1 beat expected", 32'(exp1.size() > 0), 32'd1);
      if (exp1.size() > 0) begin
        e1 = exp1.pop_front();
        chk("dut1 beat {last,id,data}", 32'({ol1, oid1, od1}), 32'(e1));
      end
    end
  end

  // Fairness: grants taken by other channels while a channel is pending
  always @(negedge clk) begin
    if (rnd_mode && !reset) begin
      for (int g = 0; g < CH; g++) begin
        if (iv0[g] && ir0[g]) begin
          for (int c = 0; c < CH; c++) begin
            if (c != g && iv0[c]) begin
              waitc[c]++;
              if (waitc[c] > max_wait) max_wait = waitc[c];
            end
          end
          waitc[g] = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  logic [3:0] ir_a [5];
  logic       drained;

  initial begin
    reset = 1'b1; sel = 1'b0; gen_en = 1'b0; rnd_mode = 1'b0; drv_oready = 1'b1;
    ir_a[0] = 4'b0010; ir_a[1] = 4'b0100; ir_a[2] = 4'b1000;
    ir_a[3] = 4'b0001; ir_a[4] = 4'b0000;

    // All channels valid, free-running output
    beat(0, 8'h00, 1'b0); beat(0, 8'h01, 1'b0);
    beat(1, 8'h10, 1'b0); beat(2, 8'h20, 1'b0); beat(3, 8'h30, 1'b0);
    ex0(0, 8'h00, 0); ex0(1, 8'h10, 0); ex0(2, 8'h20, 0);
    ex0(3, 8'h30, 0); ex0(0, 8'h01, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(ov0), 32'd0);
    chk("reset out_data", 32'(od0), 32'd0);
    chk("reset out_id", 32'(oid0), 32'd0);
    chk("reset out_last", 32'(ol0), 32'd0);
    chk("reset in_ready", 32'(ir0), 32'd0);
    chk("reset dut1 out_valid", 32'(ov1), 32'd0);
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk);
    chk("A first in_ready", 32'(ir0), 32'b0001);
    chk("A out_valid before transfer", 32'(ov0), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("A out_valid streaming", 32'(ov0), 32'd1);
      chk("A in_ready rotation", 32'(ir0), 32'(ir_a[k]));
    end
    @(negedge clk);
    chk("A out_valid after drain", 32'(ov0), 32'd0);
    repeat (3) @(negedge clk);
    chk("A all beats seen", 32'(exp0.size()), 32'd0);

    // Single channel with output stall
    @(posedge clk); #2;
    drv_oready = 1'b0;
    beat(2, 8'hA5, 1'b0); beat(2, 8'h5A, 1'b0);
    ex0(2, 8'hA5, 0); ex0(2, 8'h5A, 0);
    @(negedge clk);
    @(negedge clk);
    chk("B in_ready ch2", 32'(ir0), 32'b0100);
    chk("B out_valid empty", 32'(ov0), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("B stall out_valid", 32'(ov0), 32'd1);
      chk("B stall out_data", 32'(od0), 32'hA5);
      chk("B stall out_id", 32'(oid0), 32'd2);
      chk("B stall in_ready", 32'(ir0), 32'd0);
    end
    @(posedge clk); #2; drv_oready = 1'b1;
    @(negedge clk);
    chk("B in_ready after release", 32'(ir0), 32'b0100);
    repeat (5) @(negedge clk);
    chk("B all beats seen", 32'(exp0.size()), 32'd0);

    // Per-beat mode: channel 0 packet with a mid-packet stall vs channel 1
    @(posedge clk); #2;
    beat(0, 8'hC0, 1'b0); beat(0, 8'hC1, 1'b0); gap(0); gap(0); beat(0, 8'hC2, 1'b1);
    beat(1, 8'hD0, 1'b0); beat(1, 8'hD1, 1'b1);
    ex0(0, 8'hC0, 0); ex0(1, 8'hD0, 0); ex0(0, 8'hC1, 0);
    ex0(1, 8'hD1, 0); ex0(0, 8'hC2, 0);
    repeat (12) @(negedge clk);
    chk("C all beats seen", 32'(exp0.size()), 32'd0);

    // Packet mode: same stimulus on dut1
    @(posedge clk); #2;
    sel = 1'b1;
    beat(0, 8'hC0, 1'b0); beat(0, 8'hC1, 1'b0); gap(0); gap(0); beat(0, 8'hC2, 1'b1);
    beat(1, 8'hD0, 1'b0); beat(1, 8'hD1, 1'b1);
    ex1(0, 8'hC0, 0); ex1(0, 8'hC1, 0); ex1(0, 8'hC2, 1);
    ex1(1, 8'hD0, 0); ex1(1, 8'hD1, 1);
    @(negedge clk);
    @(negedge clk);
    chk("D first grant", 32'(ir1), 32'b0001);
    @(negedge clk);
    chk("D locked after beat 1", 32'(ir1), 32'b0001);
    @(negedge clk);
    chk("D locked during stall", 32'(ir1), 32'b0001);
    chk("D out_valid beat 2", 32'(ov1), 32'd1);
    @(negedge clk);
    chk("D locked stall 2", 32'(ir1), 32'b0001);
    chk("D out_valid bubble", 32'(ov1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("D ch1 after last", 32'(ir1), 32'b0010);
    repeat (6) @(negedge clk);
    chk("D all beats seen", 32'(exp1.size()), 32'd0);

    // Reset while a beat is held and a packet is locked
    @(posedge clk); #2;
    drv_oready = 1'b0;
    beat(0, 8'hF0, 1'b0); beat(1, 8'h81, 1'b1);
    ex1(1, 8'h81, 1); ex1(3, 8'h83, 1);
    @(negedge clk);
    @(negedge clk);
    chk("E grant ch0", 32'(ir1), 32'b0001);
    @(negedge clk);
    chk("E held out_valid", 32'(ov1), 32'd1);
    chk("E held out_data", 32'(od1), 32'hF0);
    chk("E held in_ready", 32'(ir1), 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    beat(3, 8'h83, 1'b1);
    @(negedge clk);
    chk("E in_ready during reset", 32'(ir1), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("E out_valid cleared", 32'(ov1), 32'd0);
    chk("E out_data cleared", 32'(od1), 32'd0);
    chk("E out_id cleared", 32'(oid1), 32'd0);
    chk("E out_last cleared", 32'(ol1), 32'd0);
    chk("E restart grants ch1", 32'(ir1), 32'b0010);
    @(posedge clk); #2;
    drv_oready = 1'b1;
    @(negedge clk);
    chk("E then ch3", 32'(ir1), 32'b1000);
    repeat (6) @(negedge clk);
    chk("E all beats seen", 32'(exp1.size()), 32'd0);

    // Random traffic on the per-beat instance
    @(posedge clk); #2;
    sel = 1'b0;
    rnd_mode = 1'b1;
    gen_en = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      @(posedge clk); #2;
      drv_oready = ($urandom_range(0, 1) == 1);
    end
    gen_en = 1'b0;
    drv_oready = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 200 && !drained; k++) begin
      @(negedge clk);
      if (busy == '0 && !ov0) drained = 1'b1;
    end
    chk("rnd drain within bound", 32'(drained), 32'd1);
    rnd_mode = 1'b0;
    for (int c = 0; c < CH; c++) chk("rnd no lost beats", 32'(chq[c].size()), 32'd0);
    chk("rnd fairness bound", 32'(max_wait <= CH - 1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv_rr_mux.md
RV_RR_MUX -- requirements
Module: rv_rr_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per channel and output.
REQ-002 SHALL have parameter CHANNELS, default 4: number of ready/valid input channels, legal range 2..16.
REQ-003 SHALL have parameter PKT_MODE, default 0: 0 = per-beat arbitration; 1 = grant held until the beat with in_last set.
REQ-004 SHALL derive localparam ID_W = $clog2(CHANNELS).
REQ-005 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, CHANNELS: per-channel valid.
REQ-008 SHALL have port in_ready, output, CHANNELS: per-channel ready.
REQ-009 SHALL have port in_data, input, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port in_last, input, CHANNELS: per-channel end-of-packet flag, ignored when PKT_MODE=0.
REQ-011 SHALL have port out_valid, output, 1: output holds a beat.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts.
REQ-013 SHALL have port out_data, output, WIDTH: registered beat data.
REQ-014 SHALL have port out_id, output, ID_W: source channel of the current output beat.
REQ-015 SHALL have port out_last, output, 1: registered in_last of the beat (0 when PKT_MODE=0).

Function
REQ-016 SHALL count a transfer on any interface only in a cycle where valid and ready are both high at the rising edge.
REQ-017 SHALL hold a single output register; load_en = !out_valid || out_ready.
REQ-018 SHALL drive in_ready[i] = load_en && (grant == i) && arb_active, where arb_active means at least one in_valid is set; all other in_ready bits are 0.
REQ-019 SHALL compute grant combinationally as the first channel with in_valid set, searching upward from ptr+1 modulo CHANNELS; ptr is the last granted channel.
REQ-020 SHALL update ptr to grant on every input transfer when PKT_MODE=0.
REQ-021 SHALL, when PKT_MODE=1, set a lock flag on a transfer with in_last=0 and force grant = ptr while locked; the lock clears on the transfer carrying in_last=1, and ptr then advances normally.
REQ-022 SHALL, while locked, keep in_ready of all other channels at 0 even if the locked channel's in_valid is low.
REQ-023 SHALL load out_data, out_id, out_last from the granted channel on a transfer and set out_valid=1; latency from input transfer to out_valid is exactly 1 cycle.
REQ-024 SHALL clear out_valid when out_ready=1 and no input transfer occurs in the same cycle.
REQ-025 SHALL sustain one beat per cycle when out_ready stays high: an output drain and an input load in the same cycle replace the register contents with no bubble.
REQ-026 SHALL hold out_data, out_id and out_last stable while out_valid=1 and out_ready=0.
REQ-027 SHALL not depend on out_ready for out_valid; combinational paths are limited to out_ready -> in_ready and in_valid -> in_ready.
REQ-028 SHALL never drop or duplicate a beat; if a channel deasserts in_valid without a transfer, no state changes.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, clear out_valid, out_data, out_id, out_last and the lock flag, and set ptr = CHANNELS-1 so that channel 0 has first priority.
REQ-030 SHALL drive in_ready all-zero in any cycle where reset=1.
REQ-031 SHALL discard any beat held in the output register and any packet in progress when reset is asserted mid-operation; arbitration restarts from channel 0.

Verification
REQ-032 SHALL verify this scenario: CHANNELS=4, reset released, all in_valid=1, out_ready=1 -> out_id sequence 0,1,2,3,0, out_valid high every cycle starting 1 cycle after the first transfer.
REQ-033 SHALL verify this scenario: only channel 2 valid with data 8'hA5, out_ready=0 for 3 cycles -> out_valid=1, out_data=8'hA5, out_id=2 held stable; in_ready=0 after the load; in_ready[2] returns to 1 in the cycle out_ready is raised.
REQ-034 SHALL verify this scenario: PKT_MODE=1, channels 0 and 1 valid, channel 0 sends 3 beats with in_last on beat 3 and stalls in_valid for 2 cycles mid-packet -> no channel 1 beat interleaves; channel 1 is granted immediately after the last beat.
REQ-035 SHALL verify this scenario: PKT_MODE=0, same stimulus as REQ-034 -> beats alternate 0,1,0,1 and out_last=0 throughout.
REQ-036 SHALL verify this scenario: reset asserted for 1 cycle while out_valid=1 and a packet is locked -> next cycle out_valid=0, lock cleared; with channels 1 and 3 valid, channel 1 is granted first.
REQ-037 SHALL verify this scenario: random valid/ready at 50% on all channels for 10k cycles -> scoreboard confirms per-channel order preserved, no loss or duplication, and no channel waits more than CHANNELS-1 grants (PKT_MODE=0).
